match_run_logger: RTL
=====================

Name: match_run_logger

Overview:
- Downstream consumer of the equal-input sequence detector's registered Out pulse train.
- Measures the length, in clock cycles, of each contiguous high run of that signal.
- Queues one record per completed run in a small FIFO, read out over a valid/ready handshake.
- Keeps saturating counts of completed runs and of records dropped on overflow, for software/debug readback.

Parameters:
RUN_W, 8, width of run-length field; saturates at 2^RUN_W-1
CNT_W, 16, width of run_count and drop_count; saturating
DEPTH, 4, record FIFO entries; power of two, >=2

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (asserted at 0)
clear  in  1  synchronous clear of all state, active-high
match_in  in  1  detector Out; sampled every rising edge
busy  out  1  high while a run is being measured (FSM in RUN)
rec_valid  out  1  FIFO non-empty
rec_ready  in  1  consumer accepts head record
rec_len  out  RUN_W  run length of head record; valid when rec_valid=1
run_count  out  CNT_W  completed runs, including dropped ones
drop_count  out  CNT_W  records lost to a full FIFO
overflow  out  1  sticky: set on the first drop

Behaviour:
- Interface decision: one clock, clk; reset is asynchronous and active-low, port name reset. Reset takes effect immediately, independent of clk.
- Reset values: FSM=IDLE, len=0, FIFO empty, busy=0, rec_valid=0, rec_len=0, run_count=0, drop_count=0, overflow=0.
- Priority at each edge: reset > clear > normal operation.
- FSM states:
  - IDLE, match_in=1: go to RUN, len<=1.
  - IDLE, match_in=0: stay in IDLE.
  - RUN, match_in=1: len<=len+1, saturating at 2^RUN_W-1.
  - RUN, match_in=0: commit len as a record, go to IDLE, len<=0.
- A run of N high samples produces a record with rec_len=min(N, 2^RUN_W-1).
- Commit latency: rec_valid rises on the edge after the edge that samples match_in=0, when the FIFO was empty.
- A 1-0-1 pattern on match_in gives two records. IDLE to RUN needs no idle gap beyond that single 0 sample.
- Commit:
  - run_count increments, saturating.
  - If the FIFO is not full, or a pop happens on the same edge, the record is written.
  - Otherwise the record is dropped, drop_count increments (saturating) and overflow<=1.
- Pop: on an edge with rec_valid&&rec_ready, the head advances.
  - Simultaneous push and pop with the FIFO full is legal; occupancy stays DEPTH.
  - Simultaneous push and pop with the FIFO empty: the new record is written, and nothing is popped because rec_valid=0.
- rec_len is driven from FIFO storage at the read pointer. It holds steady while rec_valid=1 and rec_ready=0.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. Full and empty are decoded from the MSB and the low bits.
- clear: FSM to IDLE and len=0. The in-progress run is discarded with no record. FIFO is emptied; counters and overflow go to 0.
  - match_in is ignored on the clear cycle. If it stays high afterwards, a new run starts at len=1.
- Reset mid-run or mid-handshake: everything is lost, and outputs return to their reset values asynchronously.
- busy equals (state==RUN).

Optional Feature:
- Macro: MATCH_RUN_TIMESTAMP_EN.
- When defined:
  - Adds parameter TS_W (default 16).
  - Adds a free-running TS_W counter, reset to 0, wrapping, not affected by clear.
  - Adds output rec_ts[TS_W], the counter value latched on the IDLE to RUN edge and stored with the record.
- When undefined: no counter, no rec_ts port, and FIFO width is RUN_W only.

Decomposition:
- Package match_pkg holds:
  - state typedef {IDLE, RUN}
  - default widths RUN_W_DEF, CNT_W_DEF, TS_W_DEF
  - a saturating-increment function
- One sub-module, match_rec_fifo: synchronous FIFO parameterised by width and DEPTH, exposing push, pop, full, empty and head data. The FSM and counters stay in the top module.

Test Plan:
- Reset release, match_in=0 for 20 cycles -> rec_valid=0, busy=0, all counts 0.
- match_in high 5 cycles then low, rec_ready=1 -> one record rec_len=5; run_count=1; rec_valid high exactly one cycle.
- RUN_W=8, match_in high 300 cycles -> rec_len=255 (saturated).
- rec_ready=0, DEPTH=4, six runs of length 3 -> FIFO holds four records of 3; drop_count=2, overflow=1, run_count=6. Then rec_ready=1 -> four pops, rec_valid falls.
- FIFO full and a run ending on the same edge as a pop -> record accepted, drop_count unchanged, occupancy stays 4.
- clear pulsed at run cycle 3 with match_in held high 4 more cycles -> no record for the first run; next record rec_len=4. Separately, reset asserted mid-run -> outputs zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/match_pkg.sv
// match_pkg: shared types, default widths and helpers for match_run_logger.
//   state_t    : logger FSM encoding {IDLE, RUN}
//   RUN_W_DEF  : default run-length field width
//   CNT_W_DEF  : default run/drop counter width
//   TS_W_DEF   : default timestamp width (MATCH_RUN_TIMESTAMP_EN builds)
//   sat_inc    : saturating increment for fields up to 32 bits wide
package match_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int RUN_W_DEF = 8;
  localparam int CNT_W_DEF = 16;
  localparam int TS_W_DEF  = 16;

  // Increments v unless it already holds the all-ones value of a
  // 'bits'-wide field; callers cast the result back to their width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                          input int unsigned bits);
    logic [32:0] max;
    max = (33'd1 << bits) - 33'd1;
    return (v >= max[31:0]) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/match_rec_fifo.sv
// match_rec_fifo: synchronous record FIFO for match_run_logger.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clear    : synchronous flush (pointers and storage to zero)
//   i_push     : write i_data (accepted when not full, or full with a pop)
//   i_data     : record to write
//   i_pop      : advance head (ignored when empty)
//   o_full     : DEPTH records held
//   o_empty    : no records held
//   o_head     : record at the read pointer
// Pointers carry one extra wrap bit so full/empty are decoded from the MSB
// and the low index bits; DEPTH must be a power of two, >= 2.
module match_rec_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_do_pop;
  logic         w_do_push;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_head  = r_mem[r_rptr[AW-1:0]];

  // When full, the write slot equals the head slot; the head is read out
  // before this edge overwrites it, so push-with-pop at full is safe.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[AW-1:0]] <= i_data;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_do_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/match_run_logger.sv
// match_run_logger: measures each contiguous high run of match_in and
// queues one run-length record per completed run, with saturating counts.
// Optional feature macro: MATCH_RUN_TIMESTAMP_EN (adds TS_W, rec_ts).
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   clear      : synchronous clear of all state, active-high
//   match_in   : detector Out, sampled every edge
//   busy       : high while a run is measured
//   rec_valid  : record FIFO non-empty
//   rec_ready  : consumer accepts head record
//   rec_len    : run length of head record
//   run_count  : completed runs (including dropped), saturating
//   drop_count : records lost to a full FIFO, saturating
//   overflow   : sticky, set on first drop
//   rec_ts     : (MATCH_RUN_TIMESTAMP_EN) run start timestamp of head record
module match_run_logger
  import match_pkg::*;
#(
  parameter int RUN_W = RUN_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = 4
`ifdef MATCH_RUN_TIMESTAMP_EN
  , parameter int TS_W = TS_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             match_in,
  output logic             busy,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [RUN_W-1:0] rec_len,
  output logic [CNT_W-1:0] run_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow
`ifdef MATCH_RUN_TIMESTAMP_EN
  , output logic [TS_W-1:0] rec_ts
`endif
);

`ifdef MATCH_RUN_TIMESTAMP_EN
  localparam int REC_W = RUN_W + TS_W;
`else
  localparam int REC_W = RUN_W;
`endif

  state_t           r_state;
  logic [RUN_W-1:0] r_len;
  // Completed run waiting one cycle before entering the FIFO.
  logic             r_commit;
  logic [RUN_W-1:0] r_commit_len;
  logic [CNT_W-1:0] r_run_count;
  logic [CNT_W-1:0] r_drop_count;
  logic             r_overflow;

  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_drop;
  logic [REC_W-1:0] w_push_data;
  logic [REC_W-1:0] w_head;

`ifdef MATCH_RUN_TIMESTAMP_EN
  logic [TS_W-1:0]  r_ts;
  logic [TS_W-1:0]  r_run_ts;
  logic [TS_W-1:0]  r_commit_ts;

  // Free-running timestamp; only reset stops it, clear does not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_ts <= '0;
    else        r_ts <= r_ts + 1'b1;
  end

  assign w_push_data = {r_commit_ts, r_commit_len};
  assign rec_ts      = w_head[REC_W-1:RUN_W];
`else
  assign w_push_data = r_commit_len;
`endif

  assign w_pop  = !w_empty && rec_ready;
  assign w_drop = r_commit && w_full && !w_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_commit     <= 1'b0;
      r_commit_len <= '0;
      r_run_count  <= '0;
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
`ifdef MATCH_RUN_TIMESTAMP_EN
      r_run_ts     <= '0;
      r_commit_ts  <= '0;
`endif
    end else if (clear) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_commit     <= 1'b0;
      r_commit_len <= '0;
      r_run_count  <= '0;
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_commit <= 1'b0;
      case (r_state)
        IDLE: begin
          if (match_in) begin
            r_state <= RUN;
            r_len   <= RUN_W'(1);
`ifdef MATCH_RUN_TIMESTAMP_EN
            r_run_ts <= r_ts;
`endif
          end
        end
        RUN: begin
          if (match_in) begin
            r_len <= RUN_W'(sat_inc(32'(r_len), RUN_W));
          end else begin
            r_commit     <= 1'b1;
            r_commit_len <= r_len;
`ifdef MATCH_RUN_TIMESTAMP_EN
            r_commit_ts  <= r_run_ts;
`endif
            r_state      <= IDLE;
            r_len        <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_len   <= '0;
        end
      endcase

      if (r_commit) begin
        r_run_count <= CNT_W'(sat_inc(32'(r_run_count), CNT_W));
        if (w_drop) begin
          r_drop_count <= CNT_W'(sat_inc(32'(r_drop_count), CNT_W));
          r_overflow   <= 1'b1;
        end
      end
    end
  end

  match_rec_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_clear (clear),
    .i_push  (r_commit),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign busy       = (r_state == RUN);
  assign rec_valid  = !w_empty;
  assign rec_len    = w_head[RUN_W-1:0];
  assign run_count  = r_run_count;
  assign drop_count = r_drop_count;
  assign overflow   = r_overflow;

endmodule
